// File: rtl/zap_cp15_lite.sv
// zap_cp15_lite: minimal CP15 system-control coprocessor.
// Executes MCR/MRC between a 16-entry CP register bank and the core register
// file. Each request ends with a one-cycle done pulse, plus undef if the
// request was not serviced.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_copro_dav/word/reg/mode coprocessor request from decode (held until done)
//   i_reg_ack, i_reg_rd_data  core register port completion and read data
//   o_reg_en/wr/index/wr_data core register access request
//   o_copro_done, o_undef     completion pulse and undefined flag
//   o_cp_ctrl                 live value of CP register 1
module zap_cp15_lite #(
  parameter int unsigned PHY_REGS = 46,
  parameter logic [31:0] CP_ID    = 32'h4107_B000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_copro_dav,
  input  logic [31:0]                 i_copro_word,
  input  logic [$clog2(PHY_REGS)-1:0] i_copro_reg,
  input  logic [31:0]                 i_copro_mode,
  input  logic                        i_reg_ack,
  input  logic [31:0]                 i_reg_rd_data,
  output logic                        o_reg_en,
  output logic                        o_reg_wr,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_index,
  output logic [31:0]                 o_reg_wr_data,
  output logic                        o_copro_done,
  output logic                        o_undef,
  output logic [31:0]                 o_cp_ctrl
);

  localparam int unsigned IW = $clog2(PHY_REGS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, WAIT_DROP} state_t;

  state_t          state, state_n;
  logic            mrc_q, mrc_n;
  logic [3:0]      crn_q, crn_n;
  logic            undef_q, undef_n;
  logic            reg_en_n, reg_wr_n, done_n, o_undef_n;
  logic [IW-1:0]   reg_index_n;
  logic [31:0]     reg_wr_data_n;
  logic [31:0]     cp_q [16];
  logic            cp_we;
  logic            defined_c;
  logic [31:0]     cp_rd_c;
  logic            unused_c;

  // Fields that never influence decode (condition, Rd field, upper CPSR bits).
  assign unused_c = ^{i_copro_word[31:28], i_copro_word[15:12], i_copro_mode[31:5]};

  // MCR/MRC to p15 with zero opc1/opc2/CRm, outside user mode; CRn=0 is read-only.
  assign defined_c = (i_copro_word[27:24] == 4'b1110) && i_copro_word[4] &&
                     (i_copro_word[11:8] == 4'hF) && (i_copro_word[23:21] == 3'd0) &&
                     (i_copro_word[7:5] == 3'd0) && (i_copro_word[3:0] == 4'd0) &&
                     (i_copro_mode[4:0] != 5'h10) &&
                     !(!i_copro_word[20] && (i_copro_word[19:16] == 4'd0));

  // CRn=0 is the ID register, not storage.
  assign cp_rd_c = (i_copro_word[19:16] == 4'd0) ? CP_ID : cp_q[i_copro_word[19:16]];

  assign o_cp_ctrl = cp_q[1];

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    mrc_n         = mrc_q;
    crn_n         = crn_q;
    undef_n       = undef_q;
    reg_en_n      = o_reg_en;
    reg_wr_n      = o_reg_wr;
    reg_index_n   = o_reg_index;
    reg_wr_data_n = o_reg_wr_data;
    done_n        = 1'b0;
    o_undef_n     = 1'b0;
    cp_we         = 1'b0;
    case (state)
      IDLE: begin
        if (i_copro_dav) begin
          mrc_n   = i_copro_word[20];
          crn_n   = i_copro_word[19:16];
          undef_n = !defined_c;
          if (defined_c) begin
            state_n       = ACCESS;
            reg_en_n      = 1'b1;
            reg_index_n   = i_copro_reg;
            reg_wr_n      = i_copro_word[20];
            reg_wr_data_n = i_copro_word[20] ? cp_rd_c : 32'd0;
          end else begin
            state_n = DONE;
          end
        end
      end
      ACCESS: begin
        // An upstream clear wins over a same-cycle ack.
        if (!i_copro_dav) begin
          state_n  = IDLE;
          reg_en_n = 1'b0;
          reg_wr_n = 1'b0;
        end else if (i_reg_ack) begin
          state_n  = DONE;
          reg_en_n = 1'b0;
          reg_wr_n = 1'b0;
          cp_we    = !mrc_q;
        end
      end
      DONE: begin
        done_n    = 1'b1;
        o_undef_n = undef_q;
        state_n   = i_copro_dav ? WAIT_DROP : IDLE;
      end
      WAIT_DROP: begin
        if (!i_copro_dav) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, request context and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      mrc_q         <= 1'b0;
      crn_q         <= 4'd0;
      undef_q       <= 1'b0;
      o_reg_en      <= 1'b0;
      o_reg_wr      <= 1'b0;
      o_reg_index   <= IW'(0);
      o_reg_wr_data <= 32'd0;
      o_copro_done  <= 1'b0;
      o_undef       <= 1'b0;
    end else begin
      state         <= state_n;
      mrc_q         <= mrc_n;
      crn_q         <= crn_n;
      undef_q       <= undef_n;
      o_reg_en      <= reg_en_n;
      o_reg_wr      <= reg_wr_n;
      o_reg_index   <= reg_index_n;
      o_reg_wr_data <= reg_wr_data_n;
      o_copro_done  <= done_n;
      o_undef       <= o_undef_n;
    end
  end

  // CP register bank; MCR to CRn=0 is undefined so entry 0 is never written.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) cp_q[i] <= 32'd0;
    end else if (cp_we) begin
      cp_q[crn_q] <= i_reg_rd_data;
    end
  end

endmodule

// File: tb/tb_zap_cp15_lite.sv
// Self-checking bench for zap_cp15_lite: directed scenarios plus randomized
// MCR/MRC traffic against a transaction-level model of the CP bank.
module tb_zap_cp15_lite;

  localparam logic [31:0] CP_ID = 32'h4107_B000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dav;
  logic [31:0] word;
  logic [5:0]  creg;
  logic [31:0] mode;
  logic        ack;
  logic [31:0] rdd;
  logic        reg_en, reg_wr, done, undef;
  logic [5:0]  reg_index;
  logic [31:0] wr_data, cp_ctrl;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] cp_m [16];
  int          bad_bits [19];
  logic [4:0]  modes [7];

  zap_cp15_lite #(.PHY_REGS(46), .CP_ID(CP_ID)) dut (
    .i_clk(clk), .i_reset(rst), .i_copro_dav(dav), .i_copro_word(word),
    .i_copro_reg(creg), .i_copro_mode(mode), .i_reg_ack(ack), .i_reg_rd_data(rdd),
    .o_reg_en(reg_en), .o_reg_wr(reg_wr), .o_reg_index(reg_index),
    .o_reg_wr_data(wr_data), .o_copro_done(done), .o_undef(undef), .o_cp_ctrl(cp_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and check it cycle by cycle; model updates the CP bank.
  task automatic run_txn(input logic [31:0] w, input logic [4:0] m, input logic [5:0] rix,
                         input int wt, input logic [31:0] data, input int hold);
    bit          def, mrc;
    int          crn, lat;
    logic [31:0] exp_wd;
    def = (w[27:24] == 4'hE) && w[4] && (w[11:8] == 4'hF) && (w[23:21] == 3'd0) &&
          (w[7:5] == 3'd0) && (w[3:0] == 4'd0) && (m != 5'h10);
    mrc = w[20];
    crn = int'(w[19:16]);
    if (!mrc && crn == 0) def = 1'b0;
    lat    = def ? 3 + wt : 2;
    exp_wd = (crn == 0) ? CP_ID : cp_m[crn];
    dav  = 1'b1;
    word = w;
    mode = {27'd0, m};
    creg = rix;
    ack  = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (def && c <= 1 + wt) begin
        chk("reg_en_active", 32'(reg_en), 32'd1);
        chk("reg_wr", 32'(reg_wr), 32'(mrc));
        chk("reg_index", 32'(reg_index), 32'(rix));
        if (mrc) chk("reg_wr_data", wr_data, exp_wd);
      end else begin
        chk("reg_en_idle", 32'(reg_en), 32'd0);
      end
      chk("done", 32'(done), 32'(c == lat));
      chk("undef", 32'(undef), 32'(c == lat && !def));
      if (c == lat) chk("cp_ctrl", cp_ctrl, cp_m[1]);
      if (def && c == 1 + wt) begin
        ack = 1'b1;
        rdd = data;
        if (!mrc) cp_m[crn] = data;
      end else begin
        ack = 1'b0;
        rdd = $urandom;
      end
    end
    ack = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_no_en", 32'(reg_en), 32'd0);
      chk("hold_no_done", 32'(done), 32'd0);
    end
    dav = 1'b0;
    @(negedge clk);
    chk("drop_no_en", 32'(reg_en), 32'd0);
    chk("drop_no_done", 32'(done), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(reg_en), 32'd0);
    chk({tag, "_wr"}, 32'(reg_wr), 32'd0);
    chk({tag, "_index"}, 32'(reg_index), 32'd0);
    chk({tag, "_wdata"}, wr_data, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_undef"}, 32'(undef), 32'd0);
    chk({tag, "_cpctrl"}, cp_ctrl, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int          bi;
    bad_bits = '{27, 26, 25, 24, 23, 22, 21, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    modes    = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
    for (int i = 0; i < 16; i++) cp_m[i] = 32'd0;
    rst = 1'b1; dav = 1'b0; word = 32'd0; creg = 6'd0; mode = 32'd0; ack = 1'b0; rdd = 32'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // MCR c1, ack on second ACCESS cycle
    run_txn(32'hEE01_0F10, 5'h13, 6'd3, 1, 32'h0000_1005, 0);
    chk("cp_ctrl_after_mcr", cp_ctrl, 32'h0000_1005);
    // MRC c0 returns the ID
    run_txn(32'hEE10_0F10, 5'h13, 6'd5, 0, 32'd0, 0);
    // MRC c1 reads back control
    run_txn(32'hEE11_0F10, 5'h1F, 6'd45, 2, 32'd0, 0);
    // user mode, CDP, CP14, MCR to c0: all undefined
    run_txn(32'hEE01_0F10, 5'h10, 6'd3, 0, 32'd0, 0);
    run_txn(32'hEE00_0F00, 5'h13, 6'd3, 0, 32'd0, 0);
    run_txn(32'hEE01_0E10, 5'h13, 6'd3, 0, 32'd0, 0);
    run_txn(32'hEE00_0F10, 5'h13, 6'd3, 0, 32'd0, 0);
    // dav held 5 cycles after done, then reissue
    run_txn(32'hEE02_0F10, 5'h13, 6'd9, 0, 32'hCAFE_0002, 5);
    run_txn(32'hEE12_0F10, 5'h13, 6'd9, 0, 32'd0, 0);

    // abort: dav drops in ACCESS with a same-cycle ack
    dav = 1'b1; word = 32'hEE02_0F10; mode = 32'h13; creg = 6'd4; ack = 1'b0;
    @(negedge clk);
    chk("abort_en", 32'(reg_en), 32'd1);
    dav = 1'b0; ack = 1'b1; rdd = 32'hDEAD_BEEF;
    @(negedge clk);
    ack = 1'b0;
    chk("abort_en_off", 32'(reg_en), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_no_done2", 32'(done), 32'd0);
    run_txn(32'hEE12_0F10, 5'h13, 6'd4, 0, 32'd0, 0);

    // dav falls in DONE: back to IDLE directly, new request accepted at once
    dav = 1'b1; word = 32'hEE10_0F10; mode = 32'h13; creg = 6'd1;
    @(negedge clk);
    chk("ddone_en", 32'(reg_en), 32'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; dav = 1'b0;
    @(negedge clk);
    chk("ddone_done", 32'(done), 32'd1);
    run_txn(32'hEE11_0F10, 5'h13, 6'd7, 0, 32'd0, 0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      w = 32'hEE00_0F10;
      w[31:28] = 4'($urandom);
      w[20]    = 1'($urandom);
      w[19:16] = 4'($urandom);
      w[15:12] = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bi = bad_bits[$urandom_range(0, 18)];
        w[bi] = ~w[bi];
      end
      run_txn(w, modes[$urandom_range(0, 6)], 6'($urandom_range(0, 45)),
              int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
    end

    // reset during ACCESS drops the request and clears the bank
    run_txn(32'hEE01_0F10, 5'h13, 6'd2, 0, 32'h0000_00FF, 0);
    dav = 1'b1; word = 32'hEE01_0F10; mode = 32'h13; creg = 6'd6;
    @(negedge clk);
    chk("rst_pre_en", 32'(reg_en), 32'd1);
    rst = 1'b1; ack = 1'b1; rdd = 32'h1234_5678;
    @(negedge clk);
    for (int i = 0; i < 16; i++) cp_m[i] = 32'd0;
    chk_all_zero("midrst");
    rst = 1'b0; dav = 1'b0; ack = 1'b0;
    @(negedge clk);
    chk_all_zero("postrst");
    run_txn(32'hEE11_0F10, 5'h13, 6'd2, 0, 32'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
